// File: rtl/mips_run_ctrl_if.sv
// -----------------------------------------------------------------------------
// mips_run_ctrl_if
//
// Bundle between the board-level run control, the MIPS core, and the
// mips_run_ctrl sequencer.
//
// Signals
//   start           control -> ctrl   single-cycle pulse that begins a run
//   stop            control -> ctrl   level, ends the current run
//   cycle_limit     control -> ctrl   run budget in enabled cycles, 0 = unlimited
//   core_pc         core    -> ctrl   current PC of the core
//   core_ifu_Reset  ctrl    -> core   drives the core's ifu_Reset
//   core_Reset      ctrl    -> core   drives the core's Reset
//   core_en         ctrl    -> core   core clock enable
//   busy            ctrl    -> control  run in progress (reset hold or running)
//   done            ctrl    -> control  run finished, core frozen
//   cause           ctrl    -> control  0 none, 1 budget, 2 halt, 3 stop
//   cycles          ctrl    -> control  enabled cycles executed in this/last run
//
// Modports
//   master : the side that drives start/stop/cycle_limit/core_pc
//   slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface mips_run_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] cycle_limit;
    logic [31:0]      core_pc;
    logic             core_ifu_Reset;
    logic             core_Reset;
    logic             core_en;
    logic             busy;
    logic             done;
    logic [1:0]       cause;
    logic [CNT_W-1:0] cycles;

    modport master (
        output start,
        output stop,
        output cycle_limit,
        output core_pc,
        input  core_ifu_Reset,
        input  core_Reset,
        input  core_en,
        input  busy,
        input  done,
        input  cause,
        input  cycles
    );

    modport slave (
        input  start,
        input  stop,
        input  cycle_limit,
        input  core_pc,
        output core_ifu_Reset,
        output core_Reset,
        output core_en,
        output busy,
        output done,
        output cause,
        output cycles
    );
endinterface

// File: rtl/mips_run_ctrl.sv
// -----------------------------------------------------------------------------
// mips_run_ctrl
//
// Run sequencer for the single-cycle MIPS core. On a start it holds the core
// in reset for RST_CYCLES enabled cycles, then lets it execute with core_en
// high, counting enabled cycles. The run ends on an external stop, on a
// self-loop halt (PC unchanged for HALT_REPEAT consecutive samples), or when
// a nonzero cycle budget is used up. In DONE the core is frozen so its state
// can be inspected.
//
// Parameters
//   RST_CYCLES   cycles of core reset after a start (>= 1)
//   HALT_REPEAT  identical consecutive PC samples that count as a halt (>= 2)
//   CNT_W        width of the budget and cycle counter
//
// Ports
//   Clk    system clock, rising edge
//   Reset  synchronous, active-high reset of this block (does not pulse the
//          core's reset; the next start does that)
//   bus    mips_run_ctrl_if slave modport (see interface file)
//
// State table
//   state          | meaning
//   ST_IDLE        | after Reset, all outputs low, waiting for start
//   ST_RESET_HOLD  | core resets and core_en high, counting down RST_CYCLES
//   ST_RUN         | core executing, cycles counting, exit checks active
//   ST_DONE        | core frozen, done high, cause/cycles held
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module mips_run_ctrl #(
    parameter int unsigned RST_CYCLES  = 2,
    parameter int unsigned HALT_REPEAT = 3,
    parameter int unsigned CNT_W       = 32
) (
    input  logic           Clk,
    input  logic           Reset,
    mips_run_ctrl_if.slave bus
);

    localparam int unsigned RST_W  = $clog2(RST_CYCLES + 1);
    localparam int unsigned SAME_W = $clog2(HALT_REPEAT + 1);

    localparam logic [RST_W-1:0]  RST_LOAD  = RST_W'(RST_CYCLES);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(1);
    localparam logic [SAME_W-1:0] SAME_ONE  = SAME_W'(1);
    localparam logic [SAME_W-1:0] HALT_LAST = SAME_W'(HALT_REPEAT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] CAUSE_NONE   = 2'd0;
    localparam logic [1:0] CAUSE_BUDGET = 2'd1;
    localparam logic [1:0] CAUSE_HALT   = 2'd2;
    localparam logic [1:0] CAUSE_STOP   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESET_HOLD,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            r_state;
    logic [RST_W-1:0]  r_rst_cnt;
    logic [CNT_W-1:0]  r_limit;
    logic [CNT_W-1:0]  r_cycles;
    logic [1:0]        r_cause;
    logic [31:0]       r_last_pc;
    logic              r_pc_valid;
    logic [SAME_W-1:0] r_same_cnt;
    logic              r_core_rst;
    logic              r_core_en;
    logic              r_busy;
    logic              r_done;

    logic [CNT_W-1:0]  w_cycles_inc;
    logic [SAME_W-1:0] w_same_inc;
    logic              w_match;
    logic              w_halt;
    logic              w_budget;

    // The first RUN sample has no valid predecessor, so it can never match.
    assign w_match      = r_pc_valid && (bus.core_pc == r_last_pc);
    assign w_cycles_inc = r_cycles + CNT_ONE;
    assign w_same_inc   = r_same_cnt + SAME_ONE;
    // HALT_REPEAT equal samples are HALT_REPEAT-1 consecutive matches.
    assign w_halt       = w_match && (w_same_inc == HALT_LAST);
    // Compared against the incremented count so DONE lands on the edge that
    // executes the final budgeted cycle.
    assign w_budget     = (r_limit != '0) && (w_cycles_inc == r_limit);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_rst_cnt  <= '0;
            r_limit    <= '0;
            r_cycles   <= '0;
            r_cause    <= CAUSE_NONE;
            r_last_pc  <= '0;
            r_pc_valid <= 1'b0;
            r_same_cnt <= '0;
            r_core_rst <= 1'b0;
            r_core_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_state    <= ST_RESET_HOLD;
                        r_limit    <= bus.cycle_limit;
                        r_cycles   <= '0;
                        r_cause    <= CAUSE_NONE;
                        r_rst_cnt  <= RST_LOAD;
                        r_pc_valid <= 1'b0;
                        r_same_cnt <= '0;
                        r_core_rst <= 1'b1;
                        r_core_en  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                    end
                end

                ST_RESET_HOLD: begin
                    if (r_rst_cnt == RST_LAST) begin
                        r_state    <= ST_RUN;
                        r_core_rst <= 1'b0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt - RST_LAST;
                    end
                end

                ST_RUN: begin
                    // Unlimited runs wrap the counter silently.
                    r_cycles   <= w_cycles_inc;
                    r_last_pc  <= bus.core_pc;
                    r_pc_valid <= 1'b1;
                    r_same_cnt <= w_match ? w_same_inc : '0;

                    if (bus.stop || w_halt || w_budget) begin
                        r_state   <= ST_DONE;
                        r_core_en <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        if (bus.stop) begin
                            r_cause <= CAUSE_STOP;
                        end else if (w_halt) begin
                            r_cause <= CAUSE_HALT;
                        end else begin
                            r_cause <= CAUSE_BUDGET;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.core_ifu_Reset = r_core_rst;
    assign bus.core_Reset     = r_core_rst;
    assign bus.core_en        = r_core_en;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.cause          = r_cause;
    assign bus.cycles         = r_cycles;

endmodule
